// File: rtl/xalu_ctrl.sv
// xalu_ctrl: multi-cycle multiply/divide unit for the E stage.
// Owns HI/LO. The product or quotient/remainder is computed combinationally
// at launch into pending registers PH/PL. Busy is then held for a fixed
// number of cycles, and PH/PL are committed to HI/LO on the last busy edge.
// Flush abandons the operation and leaves HI/LO untouched.
module xalu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [3:0]  XALUOp_E,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Flush,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_t;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;

   localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
   localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

   state_t      state, state_nxt;
   logic [4:0]  count, count_nxt;
   logic        busy_r, busy_nxt;
   logic [31:0] hi_r, hi_nxt;
   logic [31:0] lo_r, lo_nxt;
   logic [31:0] ph, ph_nxt;
   logic [31:0] pl, pl_nxt;
   // Cleared for a divide by zero so completion leaves HI/LO alone.
   logic        wr_pend, wr_pend_nxt;

   // Signed 32x32 -> 64 product; operands are sign-extended before multiplying.
   function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] ae;
      logic signed [63:0] be;
      logic signed [63:0] p;
      ae = {{32{a[31]}}, a};
      be = {{32{b[31]}}, b};
      p  = ae * be;
      return p;
   endfunction

   // Unsigned 32x32 -> 64 product.
   function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      return p;
   endfunction

   // Signed divide returning {remainder, quotient}. Quotient truncates toward
   // zero and the remainder follows the dividend's sign. The one overflowing
   // case (most negative / -1) is pinned to quotient = dividend, remainder = 0.
   function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic signed [31:0] q;
      logic signed [31:0] r;
      sa = a;
      sb = b;
      if (b == 32'd0) begin
         q = '0;
         r = '0;
      end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
         q = sa;
         r = '0;
      end else begin
         q = sa / sb;
         r = sa % sb;
      end
      return {r, q};
   endfunction

   // Unsigned divide returning {remainder, quotient}.
   function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) begin
         q = '0;
         r = '0;
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   // State, counter, pending result and HI/LO registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         count   <= '0;
         busy_r  <= 1'b0;
         hi_r    <= '0;
         lo_r    <= '0;
         ph      <= '0;
         pl      <= '0;
         wr_pend <= 1'b0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         busy_r  <= busy_nxt;
         hi_r    <= hi_nxt;
         lo_r    <= lo_nxt;
         ph      <= ph_nxt;
         pl      <= pl_nxt;
         wr_pend <= wr_pend_nxt;
      end
   end

   // Next-state logic: flush first, then launch/move-to in IDLE, countdown otherwise.
   always_comb begin
      state_nxt   = state;
      count_nxt   = count;
      busy_nxt    = busy_r;
      hi_nxt      = hi_r;
      lo_nxt      = lo_r;
      ph_nxt      = ph;
      pl_nxt      = pl;
      wr_pend_nxt = wr_pend;

      if (Flush) begin
         state_nxt = IDLE;
         busy_nxt  = 1'b0;
         count_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  case (XALUOp_E)
                     OP_MULT: begin
                        {ph_nxt, pl_nxt} = mul_signed(A, B);
                        wr_pend_nxt      = 1'b1;
                        count_nxt        = MULT_N;
                        state_nxt        = MUL;
                        busy_nxt         = 1'b1;
                     end
                     OP_MULTU: begin
                        {ph_nxt, pl_nxt} = mul_unsigned(A, B);
                        wr_pend_nxt      = 1'b1;
                        count_nxt        = MULT_N;
                        state_nxt        = MUL;
                        busy_nxt         = 1'b1;
                     end
                     OP_DIV: begin
                        {ph_nxt, pl_nxt} = div_signed(A, B);
                        wr_pend_nxt      = (B != 32'd0);
                        count_nxt        = DIV_N;
                        state_nxt        = DIV;
                        busy_nxt         = 1'b1;
                     end
                     OP_DIVU: begin
                        {ph_nxt, pl_nxt} = div_unsigned(A, B);
                        wr_pend_nxt      = (B != 32'd0);
                        count_nxt        = DIV_N;
                        state_nxt        = DIV;
                        busy_nxt         = 1'b1;
                     end
                     OP_MTHI: hi_nxt = A;
                     OP_MTLO: lo_nxt = A;
                     default: ;
                  endcase
               end
            end
            MUL, DIV: begin
               if (count == 5'd1) begin
                  if (wr_pend) begin
                     hi_nxt = ph;
                     lo_nxt = pl;
                  end
                  count_nxt = '0;
                  state_nxt = IDLE;
                  busy_nxt  = 1'b0;
               end else begin
                  count_nxt = count - 5'd1;
               end
            end
            default: begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               count_nxt = '0;
            end
         endcase
      end
   end

   assign Busy = busy_r;
   assign HI   = hi_r;
   assign LO   = lo_r;

endmodule

// File: tb/tb_xalu_ctrl.sv
// tb_xalu_ctrl: scoreboard bench for xalu_ctrl. Stimulus pushes expected
// HI/LO/Busy snapshots (tagged with the cycle they are due) and expected
// Busy run lengths; a negedge monitor pops and compares them.
module tb_xalu_ctrl;
   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [3:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        Flush;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   always #5 clk = ~clk;

   xalu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .Start(Start), .XALUOp_E(op), .A(A), .B(B),
      .Flush(Flush), .Busy(Busy), .HI(HI), .LO(LO)
   );

   typedef struct {
      int          due;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        busy;
      string       nm;
   } exp_t;

   exp_t exp_q[$];
   int   len_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   run_len = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, req);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: compare due snapshots and Busy run lengths on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
         e = exp_q.pop_front();
         cmp({e.nm, "_missed"}, 32'(e.due), 32'(cyc));
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         cmp({e.nm, "_busy"}, {31'd0, Busy}, {31'd0, e.busy});
         cmp({e.nm, "_hi"}, HI, e.hi);
         cmp({e.nm, "_lo"}, LO, e.lo);
      end
      if (Busy === 1'b1) begin
         run_len++;
      end else if (run_len > 0) begin
         if (len_q.size() == 0) cmp("busy_len_unexpected", 32'(run_len), 32'd0);
         else cmp("busy_len", 32'(run_len), 32'(len_q.pop_front()));
         run_len = 0;
      end
   end

   // Reference result {HI,LO} computed with 64-bit integer arithmetic.
   function automatic logic [63:0] ref_res(input int o, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] hi, input logic [31:0] lo);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (o)
         1: begin sq = sa * sb; return sq; end
         2: begin up = ua * ub; return up; end
         3: begin
            if (b == 0) return {hi, lo};
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
         end
         4: begin
            if (b == 0) return {hi, lo};
            up = ua / ub;
            return {32'(ua % ub), up[31:0]};
         end
         default: return {hi, lo};
      endcase
   endfunction

   task automatic push(input int due, input logic busy, input string nm);
      exp_t e;
      e.due = due; e.hi = m_hi; e.lo = m_lo; e.busy = busy; e.nm = nm;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      Start = 1'b0; Flush = 1'b0; op = 4'd0; A = $urandom; B = $urandom;
   endtask

   // Launch a mult/div. flush_at=j flushes during busy cycle j; stray issues
   // another Start during busy cycle 2.
   task automatic run_op(input int o, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input bit stray, input string nm);
      int c, n, hl;
      logic [63:0] r;
      c  = cyc;
      n  = (o <= 2) ? MC : DC;
      hl = (flush_at == 0) ? n : flush_at;
      r  = ref_res(o, a, b, m_hi, m_lo);
      Start = 1'b1; op = 4'(o); A = a; B = b; Flush = 1'b0;
      tick();
      idle_inputs();
      for (int k = 1; k <= hl; k++) push(c + k, 1'b1, {nm, "_hold"});
      if (flush_at == 0) begin
         m_hi = r[63:32];
         m_lo = r[31:0];
      end
      push(c + hl + 1, 1'b0, {nm, "_done"});
      len_q.push_back(hl);
      for (int j = 1; j <= hl; j++) begin
         if (j == flush_at) Flush = 1'b1;
         if (stray && j == 2) begin
            Start = 1'b1; op = 4'($urandom_range(1, 6));
         end
         tick();
         idle_inputs();
      end
   endtask

   task automatic run_imm(input int o, input logic [31:0] a, input bit fl, input string nm);
      int c;
      c = cyc;
      Start = 1'b1; op = 4'(o); A = a; Flush = fl;
      tick();
      idle_inputs();
      if (!fl && o == 5) m_hi = a;
      if (!fl && o == 6) m_lo = a;
      push(c + 1, 1'b0, nm);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: timeout at cyc %0d, want completion", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int c, o, fa;
      logic [31:0] ra, rb;
      reset = 1'b1;
      idle_inputs();
      #1 reset = 1'b0;
      tick(); tick();
      push(cyc, 1'b0, "reset");
      reset = 1'b1;
      tick();

      run_op(1, 32'hFFFF_FFFD, 32'd5, 0, 1'b0, "mult_m3x5");
      run_op(2, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, "multu");
      run_op(1, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, "mult_m1x2");
      run_op(4, 32'd7, 32'd2, 0, 1'b0, "divu_7_2");
      run_op(3, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, "div_m7_2");
      run_op(3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, "div_ovf");
      run_imm(5, 32'h1234_5678, 1'b0, "mthi");
      run_imm(6, 32'h9ABC_DEF0, 1'b0, "mtlo");
      run_op(3, 32'd99, 32'd0, 0, 1'b0, "div_by0");

      run_imm(5, 32'h1111_1111, 1'b0, "set_hi");
      run_imm(6, 32'h1111_1111, 1'b0, "set_lo");
      run_op(1, 32'd3, 32'd4, 0, 1'b1, "mult_stray");
      run_imm(5, 32'h1111_1111, 1'b0, "set_hi2");
      run_imm(6, 32'h1111_1111, 1'b0, "set_lo2");
      run_op(1, 32'd3, 32'd4, 3, 1'b0, "mult_flush");
      run_op(2, 32'hDEAD_BEEF, 32'h7, MC, 1'b0, "flush_last");

      // Asynchronous reset during busy cycle 4 of a div.
      c = cyc;
      Start = 1'b1; op = 4'd3; A = 32'd1000; B = 32'd7;
      tick();
      idle_inputs();
      for (int k = 1; k <= 3; k++) push(c + k, 1'b1, "rst_div_hold");
      m_hi = '0; m_lo = '0;
      push(c + 4, 1'b0, "async_reset");
      len_q.push_back(3);
      tick(); tick(); tick();
      #2 reset = 1'b0;
      tick();
      reset = 1'b1;
      run_imm(6, 32'hCAFE_F00D, 1'b0, "mtlo_after_rst");

      for (int i = 0; i < 40; i++) begin
         o  = $urandom_range(0, 15);
         ra = $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
         if (o >= 1 && o <= 4) begin
            fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (o <= 2) ? MC : DC) : 0;
            run_op(o, ra, rb, fa, 1'($urandom_range(0, 1)), "rand_op");
         end else begin
            run_imm(o, ra, ($urandom_range(0, 7) == 0), "rand_imm");
         end
      end

      tick(); tick(); tick();
      cmp("exp_q_drained", 32'(exp_q.size()), 32'd0);
      cmp("len_q_drained", 32'(len_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
